// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit:
// funct3 size/sign codes, FSM states and byte-lane helpers.
package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mau_state_e;

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3)
      F3_B, F3_BU: be = 4'b0001 << a;
      F3_H, F3_HU: be = a[1] ? 4'b1100 : 4'b0011;
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] wd;
    case (f3)
      F3_B, F3_BU: wd = {4{sd[7:0]}};
      F3_H, F3_HU: wd = {2{sd[15:0]}};
      default:     wd = sd;
    endcase
    return wd;
  endfunction

  // Unsigned variants exist only for loads; any unlisted funct3 is rejected.
  function automatic logic access_legal(input logic [2:0] f3, input logic [1:0] a,
                                        input logic is_store);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_BU:   ok = ~is_store;
      F3_H:    ok = ~a[0];
      F3_HU:   ok = ~is_store & ~a[0];
      F3_W:    ok = (a == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory req/ack port between the access unit (master) and memory (slave).
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// Load alignment: picks the addressed byte/half from the read word and
// sign- or zero-extends it according to funct3.
module mem_load_align
  import rv_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    sel_b = rdata[{addr_lo, 3'b000} +: 8];
    sel_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    result = {{24{sel_b[7]}}, sel_b};
      F3_BU:   result = {24'h000000, sel_b};
      F3_H:    result = {{16{sel_h[15]}}, sel_h};
      F3_HU:   result = {16'h0000, sel_h};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: one multi-cycle req/ack access per load/store,
// stalling the pipeline until the access completes or times out.
module mem_access_unit
  import rv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mem_read_in,
  input  logic               mem_write_in,
  input  logic [2:0]         funct3_in,
  input  logic [31:0]        addr_in,
  input  logic [31:0]        store_data_in,
  mem_access_unit_if.master  dmem,
  output logic [31:0]        load_data_out,
  output logic               load_valid_out,
  output logic               stall_out,
  output logic               err_out,
  output logic               timeout_out
);

  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  mau_state_e  state, state_nx;
  logic        access, legal, timeout_hit;
  logic [CW-1:0] cnt;

  logic        req_q, we_q;
  logic [29:0] addr_q;
  logic [1:0]  alo_q;
  logic [2:0]  f3_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] aligned;

  assign access      = start & (mem_read_in | mem_write_in);
  assign legal       = access_legal(funct3_in, addr_in[1:0], mem_write_in);
  assign timeout_hit = (state == BUSY) && !dmem.dmem_ack && (cnt == CNT_LAST);

  mem_load_align u_align (
    .rdata   (dmem.dmem_rdata),
    .addr_lo (alo_q),
    .funct3  (f3_q),
    .result  (aligned)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // stall is gated by reset so it falls together with the async clear of req.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (access && legal) state_nx = BUSY;
      BUSY:    if (dmem.dmem_ack || timeout_hit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    stall_out = reset & (((state == IDLE) & access & legal) | (state == BUSY));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      alo_q          <= '0;
      f3_q           <= '0;
      be_q           <= '0;
      wdata_q        <= '0;
      cnt            <= '0;
      load_data_out  <= '0;
      load_valid_out <= 1'b0;
      err_out        <= 1'b0;
      timeout_out    <= 1'b0;
    end else begin
      load_valid_out <= 1'b0;
      err_out        <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            if (legal) begin
              req_q   <= 1'b1;
              we_q    <= mem_write_in;
              addr_q  <= addr_in[31:2];
              alo_q   <= addr_in[1:0];
              f3_q    <= funct3_in;
              be_q    <= lane_be(funct3_in, addr_in[1:0]);
              wdata_q <= lane_wdata(funct3_in, store_data_in);
              cnt     <= '0;
            end else begin
              err_out <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (dmem.dmem_ack) begin
            req_q <= 1'b0;
            cnt   <= '0;
            if (!we_q) begin
              load_data_out  <= aligned;
              load_valid_out <= 1'b1;
            end
          end else if (timeout_hit) begin
            req_q          <= 1'b0;
            cnt            <= '0;
            timeout_out    <= 1'b1;
            load_data_out  <= '0;
            load_valid_out <= ~we_q;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = {addr_q, 2'b00};
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed and random loads/stores
// against an arithmetic reference model, with a scripted memory responder.
module tb_mem_access_unit;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        mem_read_in = 1'b0;
  logic        mem_write_in = 1'b0;
  logic [2:0]  funct3_in = '0;
  logic [31:0] addr_in = '0;
  logic [31:0] store_data_in = '0;
  logic [31:0] load_data_out;
  logic        load_valid_out, stall_out, err_out, timeout_out;

  mem_access_unit_if dmem ();

  mem_access_unit #(.TIMEOUT_CYC(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .mem_read_in    (mem_read_in),
    .mem_write_in   (mem_write_in),
    .funct3_in      (funct3_in),
    .addr_in        (addr_in),
    .store_data_in  (store_data_in),
    .dmem           (dmem),
    .load_data_out  (load_data_out),
    .load_valid_out (load_valid_out),
    .stall_out      (stall_out),
    .err_out        (err_out),
    .timeout_out    (timeout_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    int          len;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
  } resp_t;

  req_t        req_q[$];
  resp_t       resp_q[$];
  logic [31:0] load_q[$];
  int          err_pending = 0;
  logic [31:0] last_load = '0;
  logic        tmo = 1'b0;

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_legal(input int f3, input int a, input bit st);
    if (f3 == 3 || f3 > 5) return 0;
    if (st && f3 >= 4) return 0;
    if ((f3 % 4) == 1 && (a % 2) != 0) return 0;
    if (f3 == 2 && a != 0) return 0;
    return 1;
  endfunction

  function automatic int m_size(input int f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic logic [3:0] m_be(input int f3, input int a);
    int mask;
    mask = (1 << m_size(f3)) - 1;
    return 4'(mask << a);
  endfunction

  function automatic logic [31:0] m_wdata(input int f3, input logic [31:0] sd);
    longint unsigned v;
    v = sd;
    case (m_size(f3))
      1:       return 32'((v % 256) * 64'h01010101);
      2:       return 32'((v % 65536) * 64'h00010001);
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input int f3, input int a, input logic [31:0] rd);
    longint unsigned v, span;
    int sz;
    sz   = m_size(f3);
    span = 64'd1 << (8 * sz);
    v    = (longint'(rd) >> (8 * a)) % span;
    if (f3 < 4 && sz < 4 && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  // ---------------- memory responder ----------------
  initial begin
    resp_t r;
    int    n;
    bit    active;
    n = 0;
    active = 0;
    r = '{32'h0, 1};
    dmem.dmem_ack   = 1'b0;
    dmem.dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (dmem.dmem_req) begin
        if (!active) begin
          active = 1;
          n = 0;
          if (resp_q.size() > 0) r = resp_q.pop_front();
          else r = '{32'h0, 1};
        end
        n++;
        if (n == r.lat) begin
          dmem.dmem_ack   = 1'b1;
          dmem.dmem_rdata = r.rdata;
        end else begin
          dmem.dmem_ack   = 1'b0;
          dmem.dmem_rdata = $urandom;
        end
      end else begin
        active = 0;
        dmem.dmem_ack   = ($urandom_range(0, 7) == 0);
        dmem.dmem_rdata = $urandom;
      end
    end
  end

  // ---------------- monitors ----------------
  initial begin
    int   rlen;
    bit   rprev;
    req_t cur;
    rlen = 0;
    rprev = 0;
    cur = '{32'h0, 4'h0, 1'b0, 32'h0, 0};
    forever begin
      @(negedge clk);
      if (dmem.dmem_req && !rprev) begin
        check("req_expected", req_q.size(), 1);
        if (req_q.size() > 0) begin
          cur = req_q.pop_front();
          check("dmem_addr", dmem.dmem_addr, cur.addr);
          check("dmem_be", 32'(dmem.dmem_be), 32'(cur.be));
          check("dmem_we", 32'(dmem.dmem_we), 32'(cur.we));
          if (cur.we) check("dmem_wdata", dmem.dmem_wdata, cur.wdata);
        end
        rlen = 0;
      end
      if (dmem.dmem_req) rlen++;
      if (!dmem.dmem_req && rprev) check("req_length", rlen, cur.len);
      rprev = dmem.dmem_req;
    end
  end

  initial forever begin
    @(negedge clk);
    if (reset && load_valid_out) begin
      check("load_valid_expected", 32'(load_q.size() > 0), 1);
      if (load_q.size() > 0) check("load_data", load_data_out, load_q.pop_front());
    end
  end

  initial forever begin
    @(negedge clk);
    if (reset && err_out) begin
      check("err_expected", 32'(err_pending > 0), 1);
      if (err_pending > 0) err_pending--;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; returns at the negedge after the pipeline advanced.
  task automatic do_access(input bit rd, input bit wr, input int f3, input logic [31:0] addr,
                           input logic [31:0] sd, input logic [31:0] rdata, input int lat);
    bit          lg;
    int          stalls, blen;
    logic [31:0] exp_ld;
    lg     = m_legal(f3, int'(addr[1:0]), wr);
    blen   = (lat == 0) ? TO : lat;
    exp_ld = (lat == 0) ? 32'h0 : m_load(f3, int'(addr[1:0]), rdata);
    if (lg) begin
      resp_q.push_back('{rdata, lat});
      req_q.push_back('{{addr[31:2], 2'b00}, m_be(f3, int'(addr[1:0])), wr,
                        m_wdata(f3, sd), blen});
      if (!wr) load_q.push_back(exp_ld);
    end else begin
      err_pending++;
    end
    start = 1'b1;
    mem_read_in = rd;
    mem_write_in = wr;
    funct3_in = 3'(f3);
    addr_in = addr;
    store_data_in = sd;
    #1;
    stalls = 0;
    while (stall_out && stalls < 300) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    check("stall_cycles", stalls, lg ? blen + 1 : 0);
    @(negedge clk);
    start = 1'b0;
    mem_read_in = 1'b0;
    mem_write_in = 1'b0;
    if (lg && !wr) last_load = exp_ld;
    if (lg && lat == 0) begin
      tmo = 1'b1;
      last_load = 32'h0;
    end
    #1;
    check("load_data_hold", load_data_out, last_load);
    check("timeout_flag", 32'(timeout_out), 32'(tmo));
  endtask

  task automatic bubble();
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      mem_read_in = $urandom_range(0, 1);
      mem_write_in = $urandom_range(0, 1);
      addr_in = $urandom;
      @(negedge clk);
    end
    mem_read_in = 1'b0;
    mem_write_in = 1'b0;
  endtask

  task automatic random_access();
    bit rd, wr;
    int sel;
    sel = $urandom_range(0, 2);
    rd = (sel != 1);
    wr = (sel != 0);
    do_access(rd, wr, $urandom_range(0, 7), $urandom, $urandom, $urandom,
              $urandom_range(1, 5));
    bubble();
  endtask

  initial begin
    #1;
    check("rst_req", 32'(dmem.dmem_req), 0);
    check("rst_stall", 32'(stall_out), 0);
    check("rst_load_valid", 32'(load_valid_out), 0);
    check("rst_err", 32'(err_out), 0);
    check("rst_timeout", 32'(timeout_out), 0);
    check("rst_load_data", load_data_out, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    do_access(0, 1, 2, 32'h100, 32'hDEADBEEF, 32'h0, 1);
    do_access(1, 0, 0, 32'h103, 32'h0, 32'h80112233, 1);
    check("lb_result", load_data_out, 32'hFFFFFF80);
    do_access(1, 0, 4, 32'h103, 32'h0, 32'h80112233, 1);
    check("lbu_result", load_data_out, 32'h00000080);
    do_access(0, 1, 1, 32'h102, 32'h00001234, 32'h0, 2);
    do_access(1, 0, 5, 32'h102, 32'h0, 32'hBEEF0000, 3);
    check("lhu_result", load_data_out, 32'h0000BEEF);
    do_access(1, 0, 2, 32'h101, 32'h0, 32'h0, 1);
    do_access(1, 0, 3, 32'h100, 32'h0, 32'h0, 1);
    do_access(1, 1, 0, 32'h0000_0042, 32'h0000_00A5, 32'h0, 1);

    for (int i = 0; i < 60; i++) random_access();

    do_access(1, 0, 2, 32'h300, 32'h0, 32'h0, 0);
    for (int i = 0; i < 5; i++) random_access();

    // Reset in the middle of an access that will never be acknowledged.
    resp_q.push_back('{32'h0, 0});
    req_q.push_back('{32'h400, 4'hF, 1'b0, 32'h0, 5});
    start = 1'b1;
    mem_read_in = 1'b1;
    funct3_in = 3'b010;
    addr_in = 32'h400;
    @(negedge clk);
    start = 1'b0;
    mem_read_in = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    mem_read_in = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("midrst_req", 32'(dmem.dmem_req), 0);
    check("midrst_stall", 32'(stall_out), 0);
    check("midrst_timeout", 32'(timeout_out), 0);
    start = 1'b0;
    mem_read_in = 1'b0;
    tmo = 1'b0;
    last_load = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    do_access(1, 0, 2, 32'h200, 32'h0, 32'hCAFEF00D, 2);
    check("lw_after_reset", load_data_out, 32'hCAFEF00D);
    for (int i = 0; i < 5; i++) random_access();

    repeat (3) @(negedge clk);
    check("pending_req", req_q.size(), 0);
    check("pending_load", load_q.size(), 0);
    check("pending_err", err_pending, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
